// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, parity codes, FSM states and the
// frame-length helper used by both transmit and receive paths.
package uart_pkg;

    localparam int unsigned FRAME_W = 11;

    localparam logic [1:0] PAR_NONE0 = 2'b00;
    localparam logic [1:0] PAR_ODD   = 2'b01;
    localparam logic [1:0] PAR_EVEN  = 2'b10;
    localparam logic [1:0] PAR_NONE3 = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Start + data + optional parity + stop bits, clipped to the frame width.
    function automatic logic [3:0] frame_nbits(input logic       data_len,
                                               input logic [1:0] parity_type,
                                               input logic       stop_bits);
        logic [3:0] n;
        logic       par_en;
        par_en = !((parity_type == PAR_NONE0) || (parity_type == PAR_NONE3));
        n = 4'd1 + (data_len ? 4'd8 : 4'd7) + (par_en ? 4'd1 : 4'd0) +
            (stop_bits ? 4'd2 : 4'd1);
        return (n > 4'd11) ? 4'd11 : n;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Baud-period tick generator: counts 0..BAUD_DIV-1 while enabled and flags the
// last cycle of each period.
module baud_tick_gen #(
    parameter int unsigned BAUD_DIV = 5208,
    parameter int unsigned CNT_W    = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic en,
    output logic tick
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    assign w_last = (r_cnt == CNT_W'(BAUD_DIV - 1));
    assign tick   = en && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_tx_shifter.sv
// UART transmit serializer: takes one framed word per handshake and shifts it
// out LSB first, one bit per baud period, returning the line to idle high.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV = 5208,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame_in,
    input  logic               frame_valid,
    output logic               frame_ready,
    input  logic               data_len,
    input  logic [1:0]         parity_type,
    input  logic               stop_bits,
    output logic               tx_out,
    output logic               busy,
    output logic               done
);

    state_t             r_state;
    logic [FRAME_W-1:0] r_shreg;
    logic [3:0]         r_bitcnt;
    logic [3:0]         r_nbits;
    logic               r_tx;
    logic               r_done;

    logic w_tick;
    logic w_baud_clear;
    logic w_baud_en;
    logic w_last_bit;

    assign w_baud_clear = (r_state == ST_IDLE);
    assign w_baud_en    = (r_state == ST_SEND);
    assign w_last_bit   = (r_bitcnt == r_nbits - 4'd1);

    baud_tick_gen #(
        .BAUD_DIV (BAUD_DIV),
        .CNT_W    (CNT_W)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_baud_clear),
        .en    (w_baud_en),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_shreg  <= '1;
            r_bitcnt <= 4'd0;
            r_nbits  <= 4'd0;
            r_tx     <= 1'b1;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (frame_valid) begin
                        r_shreg  <= frame_in;
                        r_tx     <= frame_in[0];
                        r_nbits  <= frame_nbits(data_len, parity_type, stop_bits);
                        r_bitcnt <= 4'd0;
                        r_state  <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (w_tick) begin
                        r_shreg  <= {1'b1, r_shreg[FRAME_W-1:1]};
                        r_bitcnt <= r_bitcnt + 4'd1;
                        r_tx     <= r_shreg[1];
                        // Last stop bit done: release the line and free the slot.
                        if (w_last_bit) begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                            r_done  <= 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    assign frame_ready = (r_state == ST_IDLE);
    assign busy        = (r_state == ST_SEND);
    assign done        = r_done;
    assign tx_out      = r_tx;

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Directed, table-driven bench for uart_tx_shifter with a 4-cycle baud period.
module tb_uart_tx_shifter;

    localparam int unsigned BD = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] frame_in;
    logic        frame_valid;
    logic        frame_ready;
    logic        data_len;
    logic [1:0]  parity_type;
    logic        stop_bits;
    logic        tx_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_err    = 0;

    typedef struct {
        logic [10:0] frame;
        logic        dl;
        logic [1:0]  par;
        logic        sb;
        int          nbits;
        logic [10:0] line;  // expected line level per bit index, LSB first
    } vec_t;

    vec_t vecs[5];
    vec_t vzero;

    uart_tx_shifter #(
        .BAUD_DIV (BD),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_in    (frame_in),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .data_len    (data_len),
        .parity_type (parity_type),
        .stop_bits   (stop_bits),
        .tx_out      (tx_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            chk("idle_tx", 32'(tx_out), 32'd1);
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_ready", 32'(frame_ready), 32'd1);
            chk("idle_done", 32'(done), 32'd0);
        end
    endtask

    // Presents a frame and returns just after the accepting edge.
    task automatic start_frame(input vec_t v);
        chk("start_ready", 32'(frame_ready), 32'd1);
        frame_in    = v.frame;
        data_len    = v.dl;
        parity_type = v.par;
        stop_bits   = v.sb;
        frame_valid = 1'b1;
        @(posedge clk);
        #1;
        frame_valid = 1'b0;
        frame_in    = 11'h7FF;
    endtask

    // Checks every cycle of the frame, then the done cycle.
    task automatic check_frame(input vec_t v, input bit poke);
        for (int b = 0; b < v.nbits; b++) begin
            for (int c = 0; c < int'(BD); c++) begin
                @(negedge clk);
                chk("bit_tx", 32'(tx_out), 32'(v.line[b]));
                chk("bit_busy", 32'(busy), 32'd1);
                chk("bit_ready", 32'(frame_ready), 32'd0);
                chk("bit_done", 32'(done), 32'd0);
                if (poke && b == 3 && c == 0) begin
                    frame_in    = 11'h000;
                    data_len    = ~data_len;
                    stop_bits   = ~stop_bits;
                    frame_valid = 1'b1;
                end
                if (poke && b == 3 && c == 2) frame_valid = 1'b0;
            end
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd1);
        chk("done_tx", 32'(tx_out), 32'd1);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_ready", 32'(frame_ready), 32'd1);
    endtask

    initial begin
        // frame, data_len, parity, stop, nbits, expected line
        vecs[0] = '{11'h756, 1'b1, 2'b10, 1'b0, 11, 11'b111_0101_0110};
        vecs[1] = '{11'h7DA, 1'b0, 2'b00, 1'b1, 10, 11'b111_1101_1010};
        vecs[2] = '{11'h7FE, 1'b1, 2'b11, 1'b0, 10, 11'b111_1111_1110};
        vecs[3] = '{11'h6AA, 1'b1, 2'b01, 1'b1, 11, 11'b110_1010_1010};
        vecs[4] = '{11'h700, 1'b0, 2'b01, 1'b0, 10, 11'b111_0000_0000};
        vzero   = '{11'h000, 1'b1, 2'b10, 1'b0, 11, 11'b000_0000_0000};

        rst         = 1'b1;
        frame_in    = 11'h7FF;
        frame_valid = 1'b0;
        data_len    = 1'b0;
        parity_type = 2'b00;
        stop_bits   = 1'b0;
        #1;
        chk("reset_tx", 32'(tx_out), 32'd1);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_ready", 32'(frame_ready), 32'd1);
        chk("reset_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        idle_check(50);

        for (int i = 0; i < 5; i++) begin
            start_frame(vecs[i]);
            check_frame(vecs[i], 1'b0);
            idle_check(2);
        end

        // Back-to-back: next frame presented in the done cycle, with ignored
        // valid pulses and format changes during the first frame.
        start_frame(vecs[0]);
        check_frame(vecs[0], 1'b1);
        start_frame(vzero);
        check_frame(vzero, 1'b0);
        idle_check(3);

        // Asynchronous reset in the middle of bit 5.
        start_frame(vecs[0]);
        repeat (5 * BD + 2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx_out), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(frame_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_check(20);
        start_frame(vecs[1]);
        check_frame(vecs[1], 1'b0);
        idle_check(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_shifter.md
Name: uart_tx_shifter

Overview:
- Transmit serializer that sits directly downstream of the Framer in the UART transmitter.
- Accepts one 11-bit frame per valid/ready handshake and shifts it onto the serial line LSB first (start bit first), one bit per baud period.
- Derives the active bit count from the frame-format controls, so the line returns to idle exactly after the last stop bit.
- Contains its own baud-period tick generator.

Parameters:
- BAUD_DIV, 5208, clock cycles per serial bit (50 MHz / 9600); legal range 2..65535.
- CNT_W, 16, width of the baud counter; must satisfy 2^CNT_W > BAUD_DIV.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- frame_in  input  11  frame from Framer; bit0 = start (0), then data LSB first, then optional parity, then stop bit(s); unused upper bits are 1.
- frame_valid  input  1  frame_in and format inputs are valid this cycle.
- frame_ready  output  1  block can accept a frame this cycle.
- data_len  input  1  0 = 7 data bits, 1 = 8 data bits.
- parity_type  input  2  00/11 = no parity, 01 = odd, 10 = even.
- stop_bits  input  1  0 = 1 stop bit, 1 = 2 stop bits.
- tx_out  output  1  serial line; idle high.
- busy  output  1  high while a frame is being shifted.
- done  output  1  one-cycle pulse when the last bit period ends.

Behaviour:
- Reset (async, any time, including mid-frame):
  - State goes to IDLE; tx_out=1, busy=0, done=0, frame_ready=1.
  - Shift register is set to all 1s; baud counter and bit counter are set to 0.
  - Any in-flight frame is discarded and is never resumed.
- States: IDLE and SEND.
- IDLE:
  - frame_ready=1, tx_out=1.
  - When frame_valid=1 at a clock edge, the frame is accepted at that edge:
    - shift register <= frame_in;
    - nbits <= 1 + (data_len ? 8 : 7) + (parity_type is 01 or 10 ? 1 : 0) + (stop_bits ? 2 : 1), saturated at 11;
    - bit counter <= 0; baud counter cleared; state -> SEND.
  - Format inputs are sampled only at acceptance.
- SEND:
  - frame_ready=0, busy=1. frame_valid is ignored.
  - tx_out is registered and equals frame_in[0] starting the cycle after acceptance, so latency is 1 cycle.
  - Each bit is held for exactly BAUD_DIV cycles. A baud tick fires on the last cycle of each bit period.
  - On a tick: shift register shifts right with 1 filled into bit 10, the bit counter increments, and tx_out takes the new bit0.
  - When the tick of bit index nbits-1 fires:
    - state -> IDLE, tx_out -> 1, busy -> 0;
    - done=1 for exactly that following cycle.
  - Total frame time is nbits*BAUD_DIV cycles.
- Back-to-back frames:
  - frame_ready is high in the same cycle done is high.
  - A frame presented then is accepted, and its start bit follows the previous stop bit with no extra idle cycle.
- Widths:
  - The bit counter is 4 bits.
  - The baud counter is CNT_W bits and counts 0..BAUD_DIV-1, then wraps to 0.
- frame_in bits at index nbits or above are not transmitted. Because they are 1 in a legal frame, the line would show no difference if they were.

Decomposition:
- Shared package uart_pkg:
  - FRAME_W=11;
  - parity codes PAR_NONE0=2'b00, PAR_ODD=2'b01, PAR_EVEN=2'b10, PAR_NONE3=2'b11;
  - state encoding ST_IDLE/ST_SEND;
  - a function returning the frame bit count from data_len, parity_type and stop_bits (also reusable by the receiver).
- Sub-module baud_tick_gen:
  - Parameters BAUD_DIV and CNT_W.
  - Inputs clk, rst, clear, en; output tick.
  - tick is high on counts equal to BAUD_DIV-1 while en=1.
  - clear is synchronous and takes priority over en.

Test Plan (BAUD_DIV=4):
1. Reset then idle, no valid: tx_out=1, busy=0 and frame_ready=1 for 50 cycles; done never asserts.
2. frame_in=11'h756 (Din=8'hAB, 8-bit, even parity, 1 stop), data_len=1, parity_type=10, stop_bits=0 -> tx_out reads 0,1,1,0,1,0,1,0,1,1,1, each bit for 4 cycles (44 cycles), then done pulses once and tx_out=1.
3. Din=8'h6D, 7-bit, no parity, 2 stop: frame_in=11'h7DA, data_len=0, parity_type=00, stop_bits=1 -> 10 bits (40 cycles): 0, then 1,0,1,1,0,1,1, then 1,1; done at cycle 41.
4. Assert frame_valid again in the done cycle with 11'h000 -> the start bit begins immediately after the stop bit, with no gap; line low for 44 cycles. Also check that frame_valid pulses during SEND are ignored.
5. Assert rst at bit 5 of a frame -> tx_out=1 and busy=0 immediately, without waiting for a clock edge. After release, no residual bits are sent and a fresh frame transmits correctly.
6. parity_type=11, data_len=1, stop_bits=0 -> nbits=10 and the frame lasts 40 cycles. Also check that all-ones data (11'h7FE) produces a 4-cycle low start bit followed by a high line.
